pipe_hazard_ctrl: RTL and testbench

//  Hazard/sequencing controller for the 5-stage pipe CPU. Tracks in-flight writers (EX/MEM/WB) in a
//  3-slot scoreboard, and drives PC write enable, IF/ID hold/flush, ID/EX bubble insertion and
//  (optionally) ALU operand forwarding selects. Keeps saturating stall/flush event counters.

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/pipe_hazard_cmp.sv | 20 ++
 rtl/pipe_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipe hazard controller: action states, forward selects, scoreboard slot.
// No logic of its own; pure type and constant definitions.
// Not applicable (no handshake).
package pipe_ctrl_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  // rs/rt hold zero when the instruction does not read that operand.
  typedef struct packed {
    logic      valid;
    reg_addr_t wr_addr;
    logic      is_load;
    reg_addr_t rs;
    reg_addr_t rt;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/pipe_hazard_cmp.sv
// Compares one scoreboard writer against an rs/rt operand pair.
// Purely combinational, zero latency.
// No backpressure; outputs follow inputs.
module pipe_hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic             slot_valid,
  input  logic [REG_W-1:0] slot_wr_addr,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             use_rs,
  input  logic             use_rt,
  output logic             hit_rs,
  output logic             hit_rt
);

  assign hit_rs = slot_valid & use_rs & (slot_wr_addr == rs);
  assign hit_rt = slot_valid & use_rt & (slot_wr_addr == rt);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipe; optional forwarding under PIPE_FWD_EN.
// Control outputs combinational (zero latency); scoreboard, state and counters registered.
// Stalls hold PC and IF/ID and bubble ID/EX; a taken branch flushes IF/ID and overrides any stall.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
)(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rs_i,
  input  logic             id_uses_rt_i,
  input  logic             id_wr_en_i,
  input  logic [REG_W-1:0] id_wr_addr_i,
  input  logic             id_mem_read_i,
  input  logic             ex_branch_taken_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  slot_t            ex_q, mem_q, wb_q, ex_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic [2:0]       hit_rs, hit_rt;   // [0] EX, [1] MEM, [2] WB
  logic             stall;
  logic             unused_bits;

  pipe_hazard_cmp u_cmp_ex (
    .slot_valid(ex_q.valid), .slot_wr_addr(ex_q.wr_addr),
    .rs(id_rs_i), .rt(id_rt_i), .use_rs(id_uses_rs_i), .use_rt(id_uses_rt_i),
    .hit_rs(hit_rs[0]), .hit_rt(hit_rt[0])
  );

  pipe_hazard_cmp u_cmp_mem (
    .slot_valid(mem_q.valid), .slot_wr_addr(mem_q.wr_addr),
    .rs(id_rs_i), .rt(id_rt_i), .use_rs(id_uses_rs_i), .use_rt(id_uses_rt_i),
    .hit_rs(hit_rs[1]), .hit_rt(hit_rt[1])
  );

  pipe_hazard_cmp u_cmp_wb (
    .slot_valid(wb_q.valid), .slot_wr_addr(wb_q.wr_addr),
    .rs(id_rs_i), .rt(id_rt_i), .use_rs(id_uses_rs_i), .use_rt(id_uses_rt_i),
    .hit_rs(hit_rs[2]), .hit_rt(hit_rt[2])
  );

`ifdef PIPE_FWD_EN
  logic fa_mem, fb_mem, fa_wb, fb_wb;

  // A load in MEM has no data yet; the load-use stall keeps it from being needed.
  pipe_hazard_cmp u_fwd_mem (
    .slot_valid(mem_q.valid & ~mem_q.is_load), .slot_wr_addr(mem_q.wr_addr),
    .rs(ex_q.rs), .rt(ex_q.rt), .use_rs(1'b1), .use_rt(1'b1),
    .hit_rs(fa_mem), .hit_rt(fb_mem)
  );

  pipe_hazard_cmp u_fwd_wb (
    .slot_valid(wb_q.valid), .slot_wr_addr(wb_q.wr_addr),
    .rs(ex_q.rs), .rt(ex_q.rt), .use_rs(1'b1), .use_rt(1'b1),
    .hit_rs(fa_wb), .hit_rt(fb_wb)
  );

  // WB still stalls: the register file write lands on the edge, no write-through.
  assign stall = (ex_q.is_load & (hit_rs[0] | hit_rt[0])) | hit_rs[2] | hit_rt[2];

  always_comb begin
    fwd_a_o = FWD_REG;
    fwd_b_o = FWD_REG;
    if (rst_i) begin
      if (fa_mem)     fwd_a_o = FWD_EXMEM;
      else if (fa_wb) fwd_a_o = FWD_MEMWB;
      if (fb_mem)     fwd_b_o = FWD_EXMEM;
      else if (fb_wb) fwd_b_o = FWD_MEMWB;
    end
  end

  assign unused_bits = ^{hit_rs[1], hit_rt[1], wb_q.is_load, wb_q.rs, wb_q.rt};
`else
  assign stall       = (|hit_rs) | (|hit_rt);
  assign fwd_a_o     = FWD_REG;
  assign fwd_b_o     = FWD_REG;
  assign unused_bits = ^{wb_q.is_load, wb_q.rs, wb_q.rt};
`endif

  always_comb begin
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    state_d       = ST_RUN;
    if (rst_i) begin
      if (ex_branch_taken_i) begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b1;
        idex_bubble_o = 1'b1;
        state_d       = ST_FLUSH;
      end else if (stall) begin
        idex_bubble_o = 1'b1;
        state_d       = ST_STALL;
      end else begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
      end
    end
  end

  always_comb begin
    ex_d = SLOT_EMPTY;
    if (!idex_bubble_o) begin
      ex_d.valid   = id_wr_en_i & (id_wr_addr_i != '0);
      ex_d.wr_addr = id_wr_addr_i;
      ex_d.is_load = id_mem_read_i;
      ex_d.rs      = id_uses_rs_i ? id_rs_i : '0;
      ex_d.rt      = id_uses_rt_i ? id_rt_i : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q        <= SLOT_EMPTY;
      mem_q       <= SLOT_EMPTY;
      wb_q        <= SLOT_EMPTY;
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      state_q <= state_d;
      if (state_d == ST_STALL && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (state_d == ST_FLUSH && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl (CNT_W=4): distance-based reference model plus directed instruction pairs.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [4:0] id_rs_i = '0, id_rt_i = '0, id_wr_addr_i = '0;
  logic       id_uses_rs_i = 1'b0, id_uses_rt_i = 1'b0, id_wr_en_i = 1'b0;
  logic       id_mem_read_i = 1'b0, ex_branch_taken_i = 1'b0;
  logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o;
  logic [1:0] fwd_a_o, fwd_b_o, state_o;
  logic [3:0] stall_cnt_o, flush_cnt_o;

  pipe_hazard_ctrl #(.CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i),
    .id_wr_en_i(id_wr_en_i), .id_wr_addr_i(id_wr_addr_i),
    .id_mem_read_i(id_mem_read_i), .ex_branch_taken_i(ex_branch_taken_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
    .ifid_flush_o(ifid_flush_o), .idex_bubble_o(idex_bubble_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .state_o(state_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference model: every instruction that left ID is remembered with the cycle it left.
  // A writer that left d cycles ago sits d stages past ID (1=EX, 2=MEM, 3=WB).
  typedef struct {
    int       cyc;
    bit       wv;
    bit [4:0] dst;
    bit       ld;
    bit       urs, urt;
    bit [4:0] rs, rt;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  int   e_stall = 0, e_flush = 0, e_state = 0;
  bit   mdl_go = 1'b0;
  bit   haz, rd;
  int   d, ea, eb, e_pc, e_ifw, e_fl, e_bub;

  function automatic int fwd_src(input bit u, input bit [4:0] r);
    bit m, w;
    m = 1'b0; w = 1'b0;
    foreach (q[i]) begin
      if (u && q[i].wv && q[i].dst == r) begin
        if ((cyc - q[i].cyc) == 2 && !q[i].ld) m = 1'b1;
        if ((cyc - q[i].cyc) == 3)             w = 1'b1;
      end
    end
    return m ? 1 : (w ? 2 : 0);
  endfunction

  always @(negedge clk_i) begin
    if (!rst_i) begin
      chk("rst_pc_write", pc_write_o, 0);
      chk("rst_ifid_write", ifid_write_o, 0);
      chk("rst_ifid_flush", ifid_flush_o, 0);
      chk("rst_idex_bubble", idex_bubble_o, 0);
      chk("rst_fwd_a", fwd_a_o, 0);
      chk("rst_fwd_b", fwd_b_o, 0);
      chk("rst_state", state_o, 0);
      chk("rst_stall_cnt", stall_cnt_o, 0);
      chk("rst_flush_cnt", flush_cnt_o, 0);
      q.delete();
      cyc = 0; e_stall = 0; e_flush = 0; e_state = 0; mdl_go = 1'b0;
    end else begin
      haz = 1'b0;
      foreach (q[i]) begin
        d  = cyc - q[i].cyc;
        rd = q[i].wv && ((id_uses_rs_i && id_rs_i == q[i].dst) ||
                         (id_uses_rt_i && id_rt_i == q[i].dst));
        if (FWD) begin
          if (rd && ((d == 1 && q[i].ld) || d == 3)) haz = 1'b1;
        end else begin
          if (rd && d >= 1 && d <= 3) haz = 1'b1;
        end
      end
      ea = 0; eb = 0;
      if (FWD) begin
        foreach (q[i]) begin
          if ((cyc - q[i].cyc) == 1) begin
            ea = fwd_src(q[i].urs, q[i].rs);
            eb = fwd_src(q[i].urt, q[i].rt);
          end
        end
      end
      if (ex_branch_taken_i) begin
        e_pc = 1; e_ifw = 1; e_fl = 1; e_bub = 1;
      end else if (haz) begin
        e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 1;
      end else begin
        e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0;
      end
      chk("pc_write", pc_write_o, e_pc);
      chk("ifid_write", ifid_write_o, e_ifw);
      chk("ifid_flush", ifid_flush_o, e_fl);
      chk("idex_bubble", idex_bubble_o, e_bub);
      chk("fwd_a", fwd_a_o, ea);
      chk("fwd_b", fwd_b_o, eb);
      chk("state", state_o, e_state);
      chk("stall_cnt", stall_cnt_o, e_stall);
      chk("flush_cnt", flush_cnt_o, e_flush);
      mdl_go = 1'b0;
      if (ex_branch_taken_i) begin
        e_state = 2;
        if (e_flush < 15) e_flush++;
      end else if (haz) begin
        e_state = 1;
        if (e_stall < 15) e_stall++;
      end else begin
        e_state = 0;
        mdl_go  = 1'b1;
        q.push_back('{cyc, id_wr_en_i && id_wr_addr_i != 0, id_wr_addr_i, id_mem_read_i,
                      id_uses_rs_i, id_uses_rt_i, id_rs_i, id_rt_i});
      end
      cyc++;
      while (q.size() > 0 && (cyc - q[0].cyc) > 3) void'(q.pop_front());
    end
  end

  task automatic drive(input bit [4:0] rs, input bit [4:0] rt, input bit urs, input bit urt,
                       input bit wen, input bit [4:0] wa, input bit ld, input bit br);
    @(posedge clk_i); #1;
    id_rs_i = rs; id_rt_i = rt; id_uses_rs_i = urs; id_uses_rt_i = urt;
    id_wr_en_i = wen; id_wr_addr_i = wa; id_mem_read_i = ld; ex_branch_taken_i = br;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called at negedge+1 of the first cycle the instruction sits in ID.
  task automatic wait_issue(output int stalls);
    stalls = 0;
    while (!mdl_go && stalls < 50) begin
      stalls++;
      @(negedge clk_i); #1;
    end
    if (!mdl_go) chk("issue_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    id_uses_rs_i = 0; id_uses_rt_i = 0; id_wr_en_i = 0; id_mem_read_i = 0; ex_branch_taken_i = 0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
  endtask

  int n;

  initial begin
    #2 rst_i = 1'b0;
    @(negedge clk_i); #1;
    chk("t0_pc_write_in_reset", pc_write_o, 0);
    chk("t0_stall_cnt_in_reset", stall_cnt_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i); #1;
    chk("t0_pc_write_after_release", pc_write_o, 1);
    chk("t0_state_after_release", state_o, 0);

    // add $3,$1,$2 ; sub $4,$3,$5
    do_reset();
    drive(1, 2, 1, 1, 1, 3, 0, 0); @(negedge clk_i); #1; wait_issue(n);
    drive(3, 5, 1, 1, 1, 4, 0, 0); @(negedge clk_i); #1; wait_issue(n);
    chk("t1_sub_stalls", n, FWD ? 0 : 3);
    chk("t1_stall_cnt", stall_cnt_o, FWD ? 0 : 3);
    nop(); @(negedge clk_i); #1;
    chk("t1_fwd_a_sub_in_ex", fwd_a_o, FWD ? 1 : 0);
    chk("t1_fwd_b_sub_in_ex", fwd_b_o, 0);

    // lw $2,0($1) ; add $6,$2,$7
    do_reset();
    drive(1, 0, 1, 0, 1, 2, 1, 0); @(negedge clk_i); #1; wait_issue(n);
    drive(2, 7, 1, 1, 1, 6, 0, 0); @(negedge clk_i); #1;
    chk("t2_load_use_bubble", idex_bubble_o, 1);
    chk("t2_load_use_pc_hold", pc_write_o, 0);
    wait_issue(n);
    chk("t2_add_stalls", n, FWD ? 1 : 3);
    nop(); @(negedge clk_i); #1;
    chk("t2_fwd_a_from_wb", fwd_a_o, FWD ? 2 : 0);

    // lw $3 ; sub reading $3 while a taken branch resolves in EX
    do_reset();
    drive(1, 0, 1, 0, 1, 3, 1, 0); @(negedge clk_i); #1; wait_issue(n);
    drive(3, 5, 1, 1, 1, 4, 0, 1); @(negedge clk_i); #1;
    chk("t3_flush", ifid_flush_o, 1);
    chk("t3_pc_write", pc_write_o, 1);
    chk("t3_bubble", idex_bubble_o, 1);
    nop(); @(negedge clk_i); #1;
    chk("t3_flush_cnt", flush_cnt_o, 1);
    chk("t3_stall_cnt", stall_cnt_o, 0);
    chk("t3_state_flush", state_o, 2);

    // addi $0,$1,5 ; add $8,$0,$0
    do_reset();
    drive(1, 0, 1, 0, 1, 0, 0, 0); @(negedge clk_i); #1; wait_issue(n);
    drive(0, 0, 1, 1, 1, 8, 0, 0); @(negedge clk_i); #1;
    chk("t4_pc_write", pc_write_o, 1);
    chk("t4_bubble", idex_bubble_o, 0);
    wait_issue(n);
    chk("t4_stalls", n, 0);
    nop(); @(negedge clk_i); #1;
    chk("t4_fwd_a", fwd_a_o, 0);

    // repeated lw $9 ; add $6,$9,$7 pairs push the 4-bit stall counter into saturation
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(10, 0, 1, 0, 1, 9, 1, 0); @(negedge clk_i); #1; wait_issue(n);
      drive(9, 7, 1, 1, 1, 6, 0, 0);  @(negedge clk_i); #1; wait_issue(n);
    end
    chk("t5_stall_cnt_saturated", stall_cnt_o, 15);

    // reset pulse in the middle of a load-use stall
    drive(10, 0, 1, 0, 1, 9, 1, 0); @(negedge clk_i); #1; wait_issue(n);
    drive(9, 7, 1, 1, 1, 6, 0, 0);  @(negedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("t5_state_stall", state_o, 1);
    #1 rst_i = 1'b0;
    #1;
    chk("t5_stall_cnt_cleared", stall_cnt_o, 0);
    chk("t5_state_run_in_reset", state_o, 0);
    chk("t5_bubble_in_reset", idex_bubble_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i); #1;
    chk("t5_pc_write_after_reset", pc_write_o, 1);
    chk("t5_no_bubble_after_reset", idex_bubble_o, 0);

    nop(); nop(); nop();
    @(negedge clk_i); #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
